// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - shared timing constants and edge classification for the CGA line-rate halver
package cga_pkg;

    localparam int LINE_CLKS = 912;
    localparam int HS_START  = 1440;
    localparam int HS_WIDTH  = 320;
    localparam int RGBI_W    = 4;

    localparam int RAM_AW    = 10;
    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam int OUT_CW    = 11;

    localparam logic [RAM_AW-1:0] IN_SAT   = RAM_AW'(RAM_DEPTH - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(2 * LINE_CLKS - 1);
    localparam logic [OUT_CW-1:0] HS_ON    = OUT_CW'(HS_START);
    localparam logic [OUT_CW-1:0] HS_OFF   = OUT_CW'(HS_START + HS_WIDTH);

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_EVEN,
        EDGE_ODD
    } hs_edge_e;

    // A vsync edge arriving with the hsync edge forces the even treatment.
    function automatic hs_edge_e classify_edge(input logic hs_edge, input logic vs_edge,
                                               input logic par);
        if (!hs_edge) begin
            return EDGE_NONE;
        end
        if (vs_edge || !par) begin
            return EDGE_EVEN;
        end
        return EDGE_ODD;
    endfunction

endpackage

// File: rtl/cga_line_ram.sv
// rtl/cga_line_ram.sv - 1024x4 single-port line store with registered read
module cga_line_ram
    import cga_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [RGBI_W-1:0] wdata,
    output logic [RGBI_W-1:0] rdata
);

    logic [RGBI_W-1:0] mem [0:RAM_DEPTH-1];
    logic [RGBI_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cga_scanhalver.sv
// rtl/cga_scanhalver.sv - 31 kHz to 15 kHz line-rate halver with ping-pong line store
module cga_scanhalver
    import cga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic [RGBI_W-1:0] in_video,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [RGBI_W-1:0] out_video,
    output logic              line_start
);

    logic              hs_old_q, hs_old_d;
    logic              vs_old_q, vs_old_d;
    logic              par_q, par_d;
    logic              select_q, select_d;
    logic              capture_q, capture_d;
    logic              rd_sel_q, rd_sel_d;
    logic [RAM_AW-1:0] in_count_q, in_count_d;
    logic [OUT_CW-1:0] out_count_q, out_count_d;
    logic              out_hsync_q, out_hsync_d;
    logic [RGBI_W-1:0] out_video_q, out_video_d;
    logic              line_start_q, line_start_d;

    logic              hs_edge;
    logic              vs_edge;
    hs_edge_e          edge_kind;

    logic              wr_en;
    logic              we_a, we_b;
    logic [RAM_AW-1:0] addr_a, addr_b;
    logic [RAM_AW-1:0] rd_addr;
    logic [RGBI_W-1:0] rdata_a, rdata_b;

    always_comb begin
        hs_edge   = in_hsync & ~hs_old_q;
        vs_edge   = in_vsync & ~vs_old_q;
        edge_kind = classify_edge(hs_edge, vs_edge, par_q);

        hs_old_d     = in_hsync;
        vs_old_d     = in_vsync;
        par_d        = par_q;
        select_d     = select_q;
        capture_d    = capture_q;
        line_start_d = 1'b0;

        if (vs_edge) begin
            par_d = 1'b0;
        end

        case (edge_kind)
            EDGE_EVEN: begin
                par_d        = 1'b1;
                select_d     = ~select_q;
                capture_d    = 1'b1;
                line_start_d = 1'b1;
            end
            EDGE_ODD: begin
                par_d     = 1'b0;
                capture_d = 1'b0;
            end
            default: ;
        endcase

        if (hs_edge) begin
            in_count_d = '0;
        end else if (in_count_q == IN_SAT) begin
            in_count_d = in_count_q;
        end else begin
            in_count_d = in_count_q + 1'b1;
        end

        // An even edge restarts the output line even if the previous one was short.
        if (edge_kind == EDGE_EVEN || out_count_q == OUT_LAST) begin
            out_count_d = '0;
        end else begin
            out_count_d = out_count_q + 1'b1;
        end

        out_hsync_d = out_hsync_q;
        if (out_count_q == HS_ON) begin
            out_hsync_d = 1'b1;
        end else if (out_count_q == HS_OFF) begin
            out_hsync_d = 1'b0;
        end

        // rd_sel_q lines up with the registered RAM read of the previous cycle.
        rd_sel_d    = ~select_q;
        out_video_d = rd_sel_q ? rdata_a : rdata_b;
    end

    // Address 1023 is never written so a saturated counter cannot clobber the line.
    assign wr_en   = capture_q && (in_count_q != IN_SAT);
    assign rd_addr = out_count_q[OUT_CW-1:1];
    assign we_a    = wr_en & select_q;
    assign we_b    = wr_en & ~select_q;
    assign addr_a  = select_q ? in_count_q : rd_addr;
    assign addr_b  = select_q ? rd_addr : in_count_q;

    cga_line_ram u_ram_a (
        .clk   (clk),
        .we    (we_a),
        .addr  (addr_a),
        .wdata (in_video),
        .rdata (rdata_a)
    );

    cga_line_ram u_ram_b (
        .clk   (clk),
        .we    (we_b),
        .addr  (addr_b),
        .wdata (in_video),
        .rdata (rdata_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_old_q     <= 1'b0;
            vs_old_q     <= 1'b0;
            par_q        <= 1'b0;
            select_q     <= 1'b0;
            capture_q    <= 1'b0;
            rd_sel_q     <= 1'b0;
            in_count_q   <= '0;
            out_count_q  <= '0;
            out_hsync_q  <= 1'b0;
            out_video_q  <= '0;
            line_start_q <= 1'b0;
        end else begin
            hs_old_q     <= hs_old_d;
            vs_old_q     <= vs_old_d;
            par_q        <= par_d;
            select_q     <= select_d;
            capture_q    <= capture_d;
            rd_sel_q     <= rd_sel_d;
            in_count_q   <= in_count_d;
            out_count_q  <= out_count_d;
            out_hsync_q  <= out_hsync_d;
            out_video_q  <= out_video_d;
            line_start_q <= line_start_d;
        end
    end

    assign out_hsync  = out_hsync_q;
    assign out_vsync  = vs_old_q;
    assign out_video  = out_video_q;
    assign line_start = line_start_q;

endmodule

// File: doc/cga_scanhalver.md
# cga_scanhalver

Line-rate halver for the CGA output path: the reverse of the scandoubler. It accepts 31 kHz double-scanned video (one pixel per `clk`), captures every second input line into a ping-pong line store, and plays each captured line back at half pixel rate over two input line periods. The result is a 15 kHz CGA-rate output with regenerated hsync. It sits between any 31 kHz video source and the 15 kHz RGBI output stage.

## Interface
- `LINE_CLKS`, 912: input line length in `clk` cycles; output line is `2*LINE_CLKS`.
- `HS_START`, 1440: output count at which `out_hsync` asserts.
- `HS_WIDTH`, 320: output hsync width in `clk` cycles.
- `clk`  in  1  pixel clock (28.6364 MHz); one clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `in_hsync`  in  1  31 kHz hsync; rising edge starts an input line.
- `in_vsync`  in  1  vsync; rising edge re-aligns line parity.
- `in_video`  in  4  RGBI pixel, sampled every `clk`.
- `out_hsync`  out  1  15 kHz hsync.
- `out_vsync`  out  1  `in_vsync` delayed one `clk`.
- `out_video`  out  4  RGBI pixel at half rate (each sample held 2 clk).
- `line_start`  out  1  one-cycle pulse at each output line start.

## Operation
- Edge detect: `hs_old`/`vs_old` registered copies. Edge = input high and old low.
- Parity bit `par`. On a vsync edge, `par` <= 0. On an hsync edge:
  - `par`=0 (even edge): toggle `select`, set `capture`, `out_count` <= 0, pulse `line_start`.
  - `par`=1 (odd edge): clear `capture`.
  - Either edge: `par` toggles.
- Vsync and hsync edges in the same cycle: the hsync edge is treated as even, and `par` ends at 1.
- Input counter `in_count` (10 bits):
  - Cleared on every hsync edge; otherwise increments, saturating at 1023.
- Buffer write:
  - Write enable = `capture` and `in_count` <= 1022.
  - Address = `in_count`; target buffer = `select` (A when 1, B when 0).
  - The first pixel after the edge cycle lands at address 0.
- Output counter `out_count` (11 bits):
  - Increments every cycle and wraps from `2*LINE_CLKS-1` to 0.
  - Is also cleared by an even edge; a mid-line even edge truncates the line.
- Read address = `out_count[10:1]`, taken from buffer `~select`.
  - A line captured in one two-line period plays in the next.
- Hsync:
  - `out_hsync` <= 1 when `out_count`==`HS_START`.
  - `out_hsync` <= 0 when `out_count`==`HS_START+HS_WIDTH`.
- No input edges: output timing free-runs and the buffer replays its stale contents.

## Timing
- Reset values:
  - Outputs: `out_hsync`, `out_vsync`, `out_video`, `line_start` all 0.
  - Internal: `select`, `par`, `capture`, `in_count`, `out_count`, `hs_old`, `vs_old` all 0.
  - RAM contents are undefined.
- Reset mid-line: everything is cleared immediately. The first even edge after reset swaps to `select`=1.
- `line_start`: high in the cycle after the even edge, coincident with `out_count`=0.
- Video latency:
  - RAM read is registered; `out_video` is registered after the mux.
  - Pixel for `out_count`=n appears on `out_video` 2 clk later.
- `out_hsync` is registered: it rises the cycle after `out_count`==`HS_START`.
- Input-to-output latency: 2 input lines (one output line).
- Vertical: 524 input lines give 262 output lines. Even-numbered input lines after vsync are kept.

## Structure
- Shared package `cga_pkg`: `LINE_CLKS`, `HS_START`, `HS_WIDTH`, and the RGBI width constant (4).
- One sub-module, `cga_line_ram`:
  - 1024x4, single port, registered read, write enable.
  - Instantiated twice (A/B); the top muxes addresses by `select`.

## Test plan
- Reset asserted mid-line:
  - All outputs 0 within the same cycle.
  - After release with no input edges, `out_count` free-runs and `out_hsync` first rises 1441 clk after release.
- Ramp, two lines:
  - Drive `in_video`=addr[3:0] on even line N and 4'hF on odd line N+1.
  - Each ramp value appears on `out_video` for exactly 2 clk, starting 2 clk after the next even edge.
  - 4'hF never appears.
- Periodic input, period 912:
  - `line_start` period is 1824.
  - `out_hsync` is high for 320 clk, rising 1441 clk after each `line_start`.
- Vsync parity:
  - Assert `in_vsync` rising edge after an odd number of lines.
  - The next hsync edge is treated as even (swap and `line_start` pulse).
  - Test again with vsync and hsync edges in the same cycle; the edge is still even.
- Long input line (1100 clk):
  - Writes stop at address 1022; address 1023 holds its prior value.
  - No wrap-around overwrite of address 0.
- Short even-to-even spacing (1000 clk):
  - `out_count` is cleared at 1000, with no `out_hsync` pulse in that line.
  - `line_start` pulses.
